spu_ibr_rx: RTL and testbench
=============================

# spu_ibr_rx

Inbound response receive buffer for the SPU, placed between the NoC router ejection port and `spu_ibr_ctl`. It accepts response flits over a valid/ready handshake and unpacks their header fields. It enforces head→data ordering and drops illegal or out-of-order flits. Legal responses are queued in a small FIFO and presented on the `ib_rsp_*` valid/ready interface consumed by the response controller.

## Interface
Parameters:
- `FLIT_W`, 64, NoC flit width; must be ≥ 3 + `TID_W` + `TILE_W`.
- `TID_W`, `` `NOU_TID_WIDTH ``, transaction-ID width.
- `TILE_W`, `` `NOU_TILE_ID_WIDTH ``, tile-ID width.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock for the block.
- `rstn`  in  1  asynchronous, active-low reset.
- `noc_flit_vld`  in  1  a flit is offered by the router.
- `noc_flit_rdy`  out  1  the block can accept a flit.
- `noc_flit`  in  `FLIT_W`  flit. Fields: [1:0] type, [2] status, [3 +: TID_W] tid, [3+TID_W +: TILE_W] dst tile id. Remaining bits are ignored.
- `ib_rsp_vld`  out  1  FIFO head is valid.
- `ib_rsp_rdy`  in  1  consumer pops the FIFO head.
- `ib_rsp_type`  out  2  0 = head, 1 = data.
- `ib_rsp_tid`  out  `TID_W`  transaction ID.
- `ib_rsp_dst_tile_id`  out  `TILE_W`  destination tile ID.
- `ib_rsp_status`  out  1  response status bit, passed through unmodified.
- `seq_err`  out  1  one-cycle pulse on an ordering violation.
- `drop_cnt`  out  8  saturating count of dropped flits.

## Operation
- A flit is accepted when `noc_flit_vld && noc_flit_rdy`.
- `noc_flit_rdy = !full`, where `full` is derived from registered state only. There is no combinational path from `ib_rsp_rdy` or `noc_flit_vld` to `noc_flit_rdy`.
- Ordering FSM, one-hot, 2 states. Reset state is EXP_HEAD.
- **EXP_HEAD**
  - Accepted type 0: pushed to the FIFO; next state EXP_DATA.
  - Accepted type 1: dropped; `seq_err` pulses; `drop_cnt` increments; state stays EXP_HEAD.
- **EXP_DATA**
  - Accepted type 1: pushed; next state EXP_HEAD.
  - Accepted type 0 (orphaned head): pushed; `seq_err` pulses; state stays EXP_DATA. The new head supersedes the previous one.
- Accepted type 2 or 3, in either state: dropped; `drop_cnt` increments; state unchanged; no `seq_err`.
- A dropped flit still completes the handshake (it is consumed) and is never written to the FIFO.
- FIFO:
  - Circular buffer of `DEPTH` entries, each 3 + `TID_W` + `TILE_W` bits.
  - Pointers are log2(`DEPTH`)+1 bits wide. Full/empty is distinguished by the wrap bit.
  - A pop occurs on `ib_rsp_vld && ib_rsp_rdy`.
- `ib_rsp_vld = !empty`. The `ib_rsp_*` fields are driven from the head entry and stay stable while `ib_rsp_vld && !ib_rsp_rdy`.
- `drop_cnt` saturates at 255 and does not wrap. It clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - FIFO empty, pointers 0, FSM in EXP_HEAD.
  - `noc_flit_rdy = 1`, `ib_rsp_vld = 0`.
  - `ib_rsp_type`, `ib_rsp_tid`, `ib_rsp_dst_tile_id`, `ib_rsp_status` all 0.
  - `seq_err = 0`, `drop_cnt = 0`.
- Latency: a flit accepted at edge N into an empty FIFO gives `ib_rsp_vld = 1` in the cycle after edge N (one cycle).
- Throughput: one push and one pop per cycle.
- Simultaneous push and pop with the FIFO neither full nor empty: occupancy is unchanged.
- Simultaneous push and pop while full: cannot happen, because `rdy = 0` when full. The pop frees an entry and `rdy` rises the next cycle.
- Pop while empty: ignored.
- `seq_err` is registered and asserts the cycle after the offending accept.
- The `drop_cnt` update is visible the cycle after the drop.
- Reset mid-operation: FIFO contents are discarded, the FSM returns to EXP_HEAD, and all outputs return to their reset values immediately.

## Test plan
- Head (type 0, tid 0x12, tile 3, status 0) then data (type 1, same fields), with `ib_rsp_rdy = 1`:
  - `ib_rsp_vld` rises one cycle after each accept.
  - Fields match the input.
  - `seq_err = 0`, `drop_cnt = 0`.
- `ib_rsp_rdy = 0`, then 6 back-to-back legal flits (`DEPTH` = 4):
  - After 4 accepts, `noc_flit_rdy = 0`.
  - Head fields stay stable.
  - Raising `ib_rsp_rdy` drains in order; `rdy` returns 1 one cycle after the first pop.
- Data flit sent in EXP_HEAD: nothing is pushed; `seq_err` pulses for exactly 1 cycle; `drop_cnt = 1`.
- Head, head, data: all three are pushed; `seq_err` pulses once, after the second head; FSM ends in EXP_HEAD.
- 300 type-3 flits: no pushes, no `seq_err`, `drop_cnt` saturates at 255.
- 3 entries queued, `rstn` asserted mid-transfer: `ib_rsp_vld = 0` and `noc_flit_rdy = 1` immediately. After deassert, a single data flit is dropped, confirming the FSM is back in EXP_HEAD.

Source files
------------

// File: rtl/spu_ibr_rx.sv
// spu_ibr_rx: inbound response receive buffer between the NoC ejection port
// and spu_ibr_ctl. Unpacks response flits, enforces head->data ordering,
// drops illegal/out-of-order flits and queues legal ones in a small FIFO.

`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_TILE_ID_WIDTH
`define NOU_TILE_ID_WIDTH 4
`endif

module spu_ibr_rx #(
  parameter int FLIT_W = 64,
  parameter int TID_W  = `NOU_TID_WIDTH,
  parameter int TILE_W = `NOU_TILE_ID_WIDTH,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              noc_flit_vld,
  output logic              noc_flit_rdy,
  input  logic [FLIT_W-1:0] noc_flit,
  output logic              ib_rsp_vld,
  input  logic              ib_rsp_rdy,
  output logic [1:0]        ib_rsp_type,
  output logic [TID_W-1:0]  ib_rsp_tid,
  output logic [TILE_W-1:0] ib_rsp_dst_tile_id,
  output logic              ib_rsp_status,
  output logic              seq_err,
  output logic [7:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + TID_W + TILE_W;

  typedef enum logic [1:0] {
    EXP_HEAD = 2'b01,
    EXP_DATA = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic            full;
  logic            empty;
  logic            accept;
  logic            pop;
  logic            push;
  logic            drop;
  logic            seq_err_nxt;
  logic [1:0]      ftype;
  logic [EW-1:0]   head;
  logic            unused_flit_bits;

  assign ftype            = noc_flit[1:0];
  assign unused_flit_bits = ^noc_flit[FLIT_W-1:EW];

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign noc_flit_rdy = !full;
  assign ib_rsp_vld   = !empty;
  assign accept       = noc_flit_vld && noc_flit_rdy;
  assign pop          = ib_rsp_vld && ib_rsp_rdy;

  // Fields read as zero while empty so reset and idle present a clean bus
  assign head               = empty ? '0 : mem[rptr[AW-1:0]];
  assign ib_rsp_type        = head[1:0];
  assign ib_rsp_status      = head[2];
  assign ib_rsp_tid         = head[3 +: TID_W];
  assign ib_rsp_dst_tile_id = head[3+TID_W +: TILE_W];

  // Ordering state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= EXP_HEAD;
    else       state <= state_nxt;
  end

  // Next ordering state on each accepted flit
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        EXP_HEAD: if (ftype == 2'd0) state_nxt = EXP_DATA;
        EXP_DATA: if (ftype == 2'd1) state_nxt = EXP_HEAD;
        default:  state_nxt = EXP_HEAD;
      endcase
    end
  end

  // Push/drop/sequence-error decode for the accepted flit
  always_comb begin
    push        = 1'b0;
    drop        = 1'b0;
    seq_err_nxt = 1'b0;
    if (accept) begin
      if (ftype[1]) begin
        drop = 1'b1;
      end else begin
        case (state)
          EXP_HEAD: begin
            push        = (ftype == 2'd0);
            drop        = (ftype == 2'd1);
            seq_err_nxt = (ftype == 2'd1);
          end
          EXP_DATA: begin
            push        = 1'b1;
            seq_err_nxt = (ftype == 2'd0);
          end
          default: drop = 1'b1;
        endcase
      end
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= noc_flit[EW-1:0];
  end

  // Sequence error pulse and saturating drop counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      seq_err <= seq_err_nxt;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spu_ibr_rx.sv
// Self-checking bench for spu_ibr_rx: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.

module tb_spu_ibr_rx;

  localparam int FLIT_W = 64;
  localparam int TID_W  = 8;
  localparam int TILE_W = 4;
  localparam int DEPTH  = 4;
  localparam int EW     = 3 + TID_W + TILE_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic              noc_flit_vld;
  logic              noc_flit_rdy;
  logic [FLIT_W-1:0] noc_flit;
  logic              ib_rsp_vld;
  logic              ib_rsp_rdy;
  logic [1:0]        ib_rsp_type;
  logic [TID_W-1:0]  ib_rsp_tid;
  logic [TILE_W-1:0] ib_rsp_dst_tile_id;
  logic              ib_rsp_status;
  logic              seq_err;
  logic [7:0]        drop_cnt;

  spu_ibr_rx #(
    .FLIT_W(FLIT_W),
    .TID_W (TID_W),
    .TILE_W(TILE_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .noc_flit_vld      (noc_flit_vld),
    .noc_flit_rdy      (noc_flit_rdy),
    .noc_flit          (noc_flit),
    .ib_rsp_vld        (ib_rsp_vld),
    .ib_rsp_rdy        (ib_rsp_rdy),
    .ib_rsp_type       (ib_rsp_type),
    .ib_rsp_tid        (ib_rsp_tid),
    .ib_rsp_dst_tile_id(ib_rsp_dst_tile_id),
    .ib_rsp_status     (ib_rsp_status),
    .seq_err           (seq_err),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: expected queue contents, whether a head is expected
  // next, expected seq_err level for the coming cycle, expected drop count.
  logic [EW-1:0] q[$];
  bit            want_head;
  bit            seq_m;
  int            drops_m;
  int            pushes_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    want_head = 1'b1;
    seq_m     = 1'b0;
    drops_m   = 0;
  endfunction

  task automatic check_outputs();
    logic [EW-1:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    chk("rsp_vld",  64'(ib_rsp_vld),         64'(q.size() != 0));
    chk("flit_rdy", 64'(noc_flit_rdy),       64'(q.size() < DEPTH));
    chk("rsp_type", 64'(ib_rsp_type),        64'(h[1:0]));
    chk("rsp_stat", 64'(ib_rsp_status),      64'(h[2]));
    chk("rsp_tid",  64'(ib_rsp_tid),         64'(h[3 +: TID_W]));
    chk("rsp_tile", 64'(ib_rsp_dst_tile_id), 64'(h[3+TID_W +: TILE_W]));
    chk("seq_err",  64'(seq_err),            64'(seq_m));
    chk("drop_cnt", 64'(drop_cnt),           64'(drops_m > 255 ? 255 : drops_m));
  endtask

  // Apply inputs for one cycle, check outputs, then advance model and clock.
  task automatic cycle(input bit v, input logic [FLIT_W-1:0] f, input bit r, output bit acc);
    int unsigned t;
    bit          popped;
    noc_flit_vld = v;
    noc_flit     = f;
    ib_rsp_rdy   = r;
    #1;
    check_outputs();
    acc    = v && (q.size() < DEPTH);
    popped = r && (q.size() != 0);
    seq_m  = 1'b0;
    if (popped) void'(q.pop_front());
    if (acc) begin
      t = f[1:0];
      if (t >= 2) begin
        drops_m++;
      end else if (want_head) begin
        if (t == 0) begin q.push_back(f[EW-1:0]); pushes_m++; want_head = 1'b0; end
        else begin drops_m++; seq_m = 1'b1; end
      end else begin
        q.push_back(f[EW-1:0]);
        pushes_m++;
        if (t == 1) want_head = 1'b1;
        else        seq_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] mk(input int unsigned typ, input bit st,
                                           input int unsigned tid, input int unsigned tile);
    logic [FLIT_W-1:0] f;
    f = {$urandom, $urandom};
    f[1:0]               = typ[1:0];
    f[2]                 = st;
    f[3 +: TID_W]        = tid[TID_W-1:0];
    f[3+TID_W +: TILE_W] = tile[TILE_W-1:0];
    return f;
  endfunction

  function automatic logic [FLIT_W-1:0] rnd(input int unsigned typ);
    return mk(typ, 1'($urandom), $urandom, $urandom);
  endfunction

  task automatic idle(input int n, input bit r);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, rnd(0), r, a);
  endtask

  // Offer a flit until accepted, bounded; a timeout counts as a failure.
  task automatic send(input logic [FLIT_W-1:0] f, input bit r);
    bit a;
    int k;
    a = 1'b0;
    k = 0;
    while (!a && k < 40) begin
      cycle(1'b1, f, r, a);
      k++;
    end
    chk("send_timeout", 64'(a), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit a;
    int sent;
    int p0;
    logic [FLIT_W-1:0] fl[6];

    pushes_m     = 0;
    rstn         = 1'b0;
    noc_flit_vld = 1'b0;
    noc_flit     = '0;
    ib_rsp_rdy   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rstn = 1'b1;

    // Head then data, consumer always ready
    ib_rsp_rdy = 1'b1;
    send(mk(0, 1'b0, 'h12, 3), 1'b1);
    idle(1, 1'b1);
    send(mk(1, 1'b0, 'h12, 3), 1'b1);
    idle(2, 1'b1);

    // Consumer stalled, six legal flits offered back to back, then drain
    for (int i = 0; i < 6; i++) fl[i] = rnd(i % 2);
    sent = 0;
    for (int c = 0; c < 30 && sent < 6; c++) begin
      cycle(1'b1, fl[sent], (c >= 8), a);
      if (a) sent++;
    end
    chk("six_sent", 64'(sent), 64'd6);
    idle(6, 1'b1);

    // Data while expecting a head: dropped, single seq_err pulse
    p0 = pushes_m;
    send(rnd(1), 1'b1);
    idle(3, 1'b1);
    chk("data_in_head_pushes", 64'(pushes_m - p0), 64'd0);

    // Head, head, data: all pushed, one seq_err, back to head
    p0 = pushes_m;
    send(rnd(0), 1'b1);
    send(rnd(0), 1'b1);
    send(rnd(1), 1'b1);
    idle(3, 1'b1);
    chk("hhd_pushes", 64'(pushes_m - p0), 64'd3);

    // 300 illegal type-3 flits: counter saturates
    p0 = pushes_m;
    for (int i = 0; i < 300; i++) send(rnd(3), (i % 3) != 0);
    idle(2, 1'b1);
    chk("t3_pushes", 64'(pushes_m - p0), 64'd0);
    chk("drop_sat", 64'(drop_cnt), 64'd255);

    // Randomized traffic with fresh counter
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      cycle(($urandom_range(0, 3) != 0), rnd(sel < 4 ? 0 : sel < 8 ? 1 : sel - 6),
            1'($urandom), a);
    end
    idle(6, 1'b1);

    // Three entries queued, then reset mid-transfer
    send(rnd(0), 1'b0);
    send(rnd(1), 1'b0);
    send(rnd(0), 1'b0);
    noc_flit_vld = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    noc_flit_vld = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
    rstn = 1'b1;
    p0 = pushes_m;
    send(rnd(1), 1'b1);
    idle(2, 1'b1);
    chk("post_reset_pushes", 64'(pushes_m - p0), 64'd0);
    chk("post_reset_drop", 64'(drop_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
